// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Splits one load/store request (byte, halfword, word or doubleword) into
//   single-byte transfers on a byte-wide RAM port, one transfer per clock,
//   big-endian (lowest address = most significant byte). Returns exactly one
//   response per accepted request.
//
// Ports
//   Clk, ResetN               clock, asynchronous active-low reset
//   ReqValid/ReqReady         request handshake (ready only in IDLE)
//   ReqReadWrite              1 = load, 0 = store
//   ReqMode                   00 byte, 01 halfword, 10 word, 11 doubleword
//   ReqAddress                address of first (most significant) byte
//   ReqWData                  store data, right-justified
//   RespValid/RespError       one-cycle response pulse, error flag
//   RData                     load data, right-justified, zero-extended
//   RamEnable/RamReadWrite    byte strobe and direction (1 = read)
//   RamAddress/RamDataOut     byte address and write byte
//   RamDataIn                 read byte, valid the cycle after a read strobe
module mem_access_sequencer #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqReadWrite,
  input  logic [1:0]  ReqMode,
  input  logic [31:0] ReqAddress,
  input  logic [63:0] ReqWData,
  output logic        RespValid,
  output logic        RespError,
  output logic [63:0] RData,
  output logic        RamEnable,
  output logic        RamReadWrite,
  output logic [31:0] RamAddress,
  output logic [7:0]  RamDataOut,
  input  logic [7:0]  RamDataIn
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFER  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]  r_state;
  logic        r_rw;
  logic        r_err;
  logic [2:0]  r_last;
  logic [2:0]  r_cnt;
  logic [31:0] r_ram_addr;
  logic [63:0] r_wsh;
  logic [63:0] r_acc;
  logic [63:0] r_rdata;

  logic        w_accept;
  logic [2:0]  w_last_idx;
  logic [5:0]  w_shamt;
  logic        w_misalign;
  logic        w_oob;
  logic        w_reject;
  logic        w_in_xfer;

  assign w_accept  = ReqValid && (r_state == S_IDLE);
  assign w_in_xfer = (r_state == S_XFER);

  // N-1 for the requested size; also the alignment mask.
  always_comb begin
    w_last_idx = 3'd0;
    case (ReqMode)
      2'b00: w_last_idx = 3'd0;
      2'b01: w_last_idx = 3'd1;
      2'b10: w_last_idx = 3'd3;
      default: w_last_idx = 3'd7;
    endcase
  end

  assign w_shamt    = {3'd7 - w_last_idx, 3'b000};
  assign w_misalign = |(ReqAddress[2:0] & w_last_idx);
  assign w_oob      = (ReqAddress >= 32'(MEM_BYTES));
  assign w_reject   = w_misalign || w_oob;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state    <= S_IDLE;
      r_rw       <= 1'b1;
      r_err      <= 1'b0;
      r_last     <= '0;
      r_cnt      <= '0;
      r_ram_addr <= '0;
      r_wsh      <= '0;
      r_acc      <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rw   <= ReqReadWrite;
            r_last <= w_last_idx;
            r_cnt  <= '0;
            r_acc  <= '0;
            if (w_reject) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_state <= S_RESP;
            end else begin
              r_err      <= 1'b0;
              r_ram_addr <= ReqAddress;
              // Left-justify store data so the next byte out is always [63:56].
              r_wsh      <= ReqWData << w_shamt;
              r_state    <= S_XFER;
            end
          end
        end
        S_XFER: begin
          r_wsh <= r_wsh << 8;
          // Byte for strobe k-1 is on RamDataIn during strobe k.
          if (r_rw && (r_cnt != 3'd0)) begin
            r_acc <= {r_acc[55:0], RamDataIn};
          end
          if (r_cnt == r_last) begin
            r_state <= r_rw ? S_DRAIN : S_RESP;
          end else begin
            r_cnt      <= r_cnt + 3'd1;
            r_ram_addr <= r_ram_addr + 32'd1;
          end
        end
        S_DRAIN: begin
          r_acc   <= {r_acc[55:0], RamDataIn};
          r_rdata <= {r_acc[55:0], RamDataIn};
          r_state <= S_RESP;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ReqReady     = (r_state == S_IDLE);
  assign RespValid    = (r_state == S_RESP);
  assign RespError    = (r_state == S_RESP) && r_err;
  assign RData        = r_rdata;
  assign RamEnable    = w_in_xfer;
  assign RamReadWrite = w_in_xfer ? r_rw : 1'b1;
  assign RamAddress   = r_ram_addr;
  assign RamDataOut   = (w_in_xfer && !r_rw) ? r_wsh[63:56] : 8'h00;

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;

  logic        Clk;
  logic        ResetN;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqReadWrite;
  logic [1:0]  ReqMode;
  logic [31:0] ReqAddress;
  logic [63:0] ReqWData;
  logic        RespValid;
  logic        RespError;
  logic [63:0] RData;
  logic        RamEnable;
  logic        RamReadWrite;
  logic [31:0] RamAddress;
  logic [7:0]  RamDataOut;
  logic [7:0]  RamDataIn;

  mem_access_sequencer #(.MEM_BYTES(256)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqReadWrite(ReqReadWrite),
    .ReqMode(ReqMode), .ReqAddress(ReqAddress), .ReqWData(ReqWData),
    .RespValid(RespValid), .RespError(RespError), .RData(RData),
    .RamEnable(RamEnable), .RamReadWrite(RamReadWrite), .RamAddress(RamAddress),
    .RamDataOut(RamDataOut), .RamDataIn(RamDataIn)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Byte-wide synchronous RAM: read data appears the cycle after the strobe.
  logic [7:0] mem [256];
  logic [7:0] ram_rd;
  always @(posedge Clk) begin
    if (RamEnable) begin
      if (!RamReadWrite) mem[RamAddress[7:0]] <= RamDataOut;
      else               ram_rd <= mem[RamAddress[7:0]];
    end
  end
  assign RamDataIn = ram_rd;

  int n_pass;
  int n_total;

  // Observations captured by run_req, relative to the accept edge (cycle 0).
  int          st_n;
  int          st_cyc  [8];
  logic [31:0] st_addr [8];
  logic [7:0]  st_data [8];
  logic        st_rw   [8];
  int          resp_cyc;
  logic        resp_err;
  logic [63:0] resp_data;
  logic        rdy_resp;
  logic        rdy_after;

  task automatic run_req(input logic rw, input logic [1:0] mode,
                         input logic [31:0] addr, input logic [63:0] wd);
    st_n     = 0;
    resp_cyc = -1;
    @(negedge Clk);
    ReqValid = 1'b1; ReqReadWrite = rw; ReqMode = mode;
    ReqAddress = addr; ReqWData = wd;
    @(posedge Clk);
    #1;
    // Scramble the request inputs; the captured copy must be used.
    ReqValid = 1'b0; ReqReadWrite = ~rw; ReqMode = ~mode;
    ReqAddress = '1; ReqWData = ~wd;
    for (int c = 1; c <= 20 && resp_cyc < 0; c++) begin
      @(negedge Clk);
      if (RamEnable) begin
        if (st_n < 8) begin
          st_cyc[st_n] = c; st_addr[st_n] = RamAddress;
          st_data[st_n] = RamDataOut; st_rw[st_n] = RamReadWrite;
        end
        st_n++;
      end
      if (RespValid) begin
        resp_cyc = c; resp_err = RespError; resp_data = RData; rdy_resp = ReqReady;
      end
    end
    @(negedge Clk);
    rdy_after = ReqReady;
  endtask

  task automatic test_reset;
    n_total++; if (ReqReady !== 1'b1) $display("FAIL reset_ready: got %b exp 1", ReqReady); else n_pass++;
    n_total++; if (RamEnable !== 1'b0) $display("FAIL reset_en: got %b exp 0", RamEnable); else n_pass++;
    n_total++; if (RamReadWrite !== 1'b1) $display("FAIL reset_rw: got %b exp 1", RamReadWrite); else n_pass++;
    n_total++; if (RamAddress !== 32'h0) $display("FAIL reset_addr: got %h exp 0", RamAddress); else n_pass++;
    n_total++; if (RamDataOut !== 8'h0) $display("FAIL reset_dout: got %h exp 0", RamDataOut); else n_pass++;
    n_total++; if (RespValid !== 1'b0 || RespError !== 1'b0)
      $display("FAIL reset_resp: got %b%b exp 00", RespValid, RespError); else n_pass++;
    n_total++; if (RData !== 64'h0) $display("FAIL reset_rdata: got %h exp 0", RData); else n_pass++;
  endtask

  task automatic test_word_write;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
    run_req(1'b0, 2'b10, 32'h10, 64'h1111_2222_DEAD_BEEF);
    n_total++; if (st_n !== 4) $display("FAIL ww_strobes: got %0d exp 4", st_n); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (st_cyc[k] !== k + 1 || st_addr[k] !== 32'h10 + k || st_data[k] !== exp_b[k] || st_rw[k] !== 1'b0)
        $display("FAIL ww_xfer%0d: got cyc %0d addr %h data %h rw %b exp cyc %0d addr %h data %h rw 0",
                 k, st_cyc[k], st_addr[k], st_data[k], st_rw[k], k + 1, 32'h10 + k, exp_b[k]);
      else n_pass++;
    end
    n_total++; if (resp_cyc !== 5 || resp_err !== 1'b0)
      $display("FAIL ww_resp: got cyc %0d err %b exp cyc 5 err 0", resp_cyc, resp_err); else n_pass++;
    n_total++; if (resp_data !== 64'h0) $display("FAIL ww_rdata_hold: got %h exp 0", resp_data); else n_pass++;
    n_total++; if (rdy_resp !== 1'b0 || rdy_after !== 1'b1)
      $display("FAIL ww_ready: got resp %b after %b exp 0 1", rdy_resp, rdy_after); else n_pass++;
    n_total++; if (mem[8'h10] !== 8'hDE || mem[8'h13] !== 8'hEF)
      $display("FAIL ww_mem: got %h %h exp de ef", mem[8'h10], mem[8'h13]); else n_pass++;
  endtask

  task automatic test_word_read;
    run_req(1'b1, 2'b10, 32'h10, 64'h0);
    n_total++; if (st_n !== 4 || st_rw[0] !== 1'b1 || st_cyc[3] !== 4)
      $display("FAIL wr_strobes: got n %0d rw %b last %0d exp 4 1 4", st_n, st_rw[0], st_cyc[3]); else n_pass++;
    n_total++; if (resp_cyc !== 6 || resp_err !== 1'b0)
      $display("FAIL wr_resp: got cyc %0d err %b exp 6 0", resp_cyc, resp_err); else n_pass++;
    n_total++; if (resp_data !== 64'h0000_0000_DEAD_BEEF)
      $display("FAIL wr_rdata: got %h exp 00000000deadbeef", resp_data); else n_pass++;
  endtask

  task automatic test_halfword;
    run_req(1'b0, 2'b01, 32'h20, 64'h1234);
    n_total++; if (st_n !== 2 || st_data[0] !== 8'h12 || st_data[1] !== 8'h34 || resp_cyc !== 3)
      $display("FAIL hw_write: got n %0d %h %h cyc %0d exp 2 12 34 3", st_n, st_data[0], st_data[1], resp_cyc);
    else n_pass++;
    run_req(1'b1, 2'b00, 32'h21, 64'h0);
    n_total++; if (resp_cyc !== 3 || resp_data !== 64'h34)
      $display("FAIL br_0x21: got cyc %0d data %h exp 3 34", resp_cyc, resp_data); else n_pass++;
    run_req(1'b1, 2'b01, 32'h20, 64'h0);
    n_total++; if (resp_cyc !== 4 || resp_data !== 64'h1234)
      $display("FAIL hr_0x20: got cyc %0d data %h exp 4 1234", resp_cyc, resp_data); else n_pass++;
  endtask

  task automatic test_dword_read;
    for (int i = 0; i < 8; i++) mem[8'hF8 + i] = 8'(i + 1);
    run_req(1'b1, 2'b11, 32'hF8, 64'h0);
    n_total++; if (st_n !== 8 || st_cyc[0] !== 1 || st_cyc[7] !== 8 || st_addr[7] !== 32'hFF)
      $display("FAIL dr_strobes: got n %0d first %0d last %0d addr %h exp 8 1 8 ff",
               st_n, st_cyc[0], st_cyc[7], st_addr[7]); else n_pass++;
    n_total++; if (resp_cyc !== 10 || resp_data !== 64'h0102030405060708)
      $display("FAIL dr_rdata: got cyc %0d data %h exp 10 0102030405060708", resp_cyc, resp_data); else n_pass++;
    // A store must leave RData alone.
    run_req(1'b0, 2'b00, 32'h50, 64'h77);
    n_total++; if (resp_data !== 64'h0102030405060708)
      $display("FAIL write_keeps_rdata: got %h exp 0102030405060708", resp_data); else n_pass++;
    n_total++; if (RamAddress !== 32'h50 || RamEnable !== 1'b0 || RamReadWrite !== 1'b1 || RamDataOut !== 8'h00)
      $display("FAIL idle_ram_outs: got addr %h en %b rw %b dout %h exp 50 0 1 00",
               RamAddress, RamEnable, RamReadWrite, RamDataOut); else n_pass++;
  endtask

  task automatic test_errors;
    logic [1:0]  modes [3];
    logic [31:0] addrs [3];
    modes[0] = 2'b10; addrs[0] = 32'h02;
    modes[1] = 2'b11; addrs[1] = 32'hFC;
    modes[2] = 2'b00; addrs[2] = 32'h100;
    for (int i = 0; i < 3; i++) begin
      run_req(1'b1, modes[i], addrs[i], 64'h0);
      n_total++;
      if (resp_cyc !== 1 || resp_err !== 1'b1 || resp_data !== 64'h0 || st_n !== 0)
        $display("FAIL err%0d: got cyc %0d err %b data %h strobes %0d exp 1 1 0 0",
                 i, resp_cyc, resp_err, resp_data, st_n);
      else n_pass++;
    end
    n_total++; if (RamAddress !== 32'h50) $display("FAIL err_addr_hold: got %h exp 50", RamAddress); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [5:0] smask, rmask;
    smask = '0; rmask = '0;
    @(negedge Clk);
    ReqValid = 1'b1; ReqReadWrite = 1'b0; ReqMode = 2'b00;
    ReqAddress = 32'h30; ReqWData = 64'h5A;
    @(posedge Clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      if (RamEnable) smask[c-1] = 1'b1;
      if (RespValid) rmask[c-1] = 1'b1;
      if (c == 4) ReqValid = 1'b0;
    end
    n_total++; if (smask !== 6'b001001) $display("FAIL b2b_strobes: got %b exp 001001", smask); else n_pass++;
    n_total++; if (rmask !== 6'b010010) $display("FAIL b2b_resp: got %b exp 010010", rmask); else n_pass++;
    n_total++; if (mem[8'h30] !== 8'h5A) $display("FAIL b2b_mem: got %h exp 5a", mem[8'h30]); else n_pass++;
  endtask

  task automatic test_reset_abort;
    int saw_resp;
    run_req(1'b1, 2'b00, 32'h30, 64'h0);
    n_total++; if (resp_data !== 64'h5A) $display("FAIL pre_abort_read: got %h exp 5a", resp_data); else n_pass++;
    for (int i = 0; i < 8; i++) mem[8'h40 + i] = 8'h00;
    @(negedge Clk);
    ReqValid = 1'b1; ReqReadWrite = 1'b0; ReqMode = 2'b11;
    ReqAddress = 32'h40; ReqWData = 64'hAAAA_AAAA_AAAA_AAAA;
    @(posedge Clk);
    #1 ReqValid = 1'b0;
    repeat (3) @(posedge Clk);
    #1 ResetN = 1'b0;
    #1;
    n_total++;
    if (ReqReady !== 1'b1 || RamEnable !== 1'b0 || RamReadWrite !== 1'b1 || RamAddress !== 32'h0 ||
        RamDataOut !== 8'h0 || RespValid !== 1'b0 || RespError !== 1'b0 || RData !== 64'h0)
      $display("FAIL abort_outs: got rdy %b en %b rw %b addr %h dout %h rv %b re %b rd %h exp 1 0 1 0 0 0 0 0",
               ReqReady, RamEnable, RamReadWrite, RamAddress, RamDataOut, RespValid, RespError, RData);
    else n_pass++;
    saw_resp = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      if (RespValid) saw_resp++;
    end
    ResetN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      if (RespValid) saw_resp++;
    end
    n_total++; if (saw_resp !== 0) $display("FAIL abort_noresp: got %0d exp 0", saw_resp); else n_pass++;
    n_total++; if (mem[8'h40] !== 8'hAA || mem[8'h41] !== 8'hAA || mem[8'h42] !== 8'hAA)
      $display("FAIL abort_written: got %h %h %h exp aa aa aa", mem[8'h40], mem[8'h41], mem[8'h42]); else n_pass++;
    n_total++;
    if (mem[8'h43] !== 8'h00 || mem[8'h44] !== 8'h00 || mem[8'h45] !== 8'h00 ||
        mem[8'h46] !== 8'h00 || mem[8'h47] !== 8'h00)
      $display("FAIL abort_untouched: got %h %h %h %h %h exp 00", mem[8'h43], mem[8'h44],
               mem[8'h45], mem[8'h46], mem[8'h47]);
    else n_pass++;
    n_total++; if (ReqReady !== 1'b1) $display("FAIL abort_ready: got %b exp 1", ReqReady); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    ram_rd = 8'h00;
    ResetN = 1'b0; ReqValid = 1'b0; ReqReadWrite = 1'b1;
    ReqMode = 2'b00; ReqAddress = '0; ReqWData = '0;
    repeat (3) @(negedge Clk);
    test_reset;
    ResetN = 1'b1;
    @(negedge Clk);
    test_word_write;
    test_word_read;
    test_halfword;
    test_dword_read;
    test_errors;
    test_back_to_back;
    test_reset_abort;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
